// File: rtl/bbox_pkg.sv
// Shared definitions for the serial bounding-box accumulator: default geometry,
// accumulator operation encoding and a constant-width helper.
package bbox_pkg;

    localparam int CW_DEFAULT = 9;
    localparam int NV_DEFAULT = 3;
    localparam int L          = 2 * NV_DEFAULT * CW_DEFAULT;

    typedef enum logic [1:0] {
        ACC_HOLD,
        ACC_LOAD,
        ACC_UPDATE
    } acc_op_e;

    // Ceiling log2, never below 1 so single-state counters still get a bit.
    function automatic int bbox_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value)
            r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bbox_piso.sv
// Parallel-in serial-out register, MSB first; a load wins over a shift.
module bbox_piso #(
    parameter int W = 9
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] q_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            q_reg <= '0;
        else if (load)
            q_reg <= din;
        else if (shift)
            q_reg <= {q_reg[W-2:0], 1'b0};
    end

    assign msb = q_reg[W-1];

endmodule

// File: rtl/bbox_serial_acc.sv
// Bit-serial bounding-box accumulator: running min/max over NV (x,y) vertices,
// limits shifted out MSB first while the next frame streams in.
module bbox_serial_acc
    import bbox_pkg::*;
#(
    parameter int CW = CW_DEFAULT,
    parameter int NV = NV_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    input  logic EN,
    output logic XMINI,
    output logic XMAXI,
    output logic YMINI,
    output logic YMAXI,
    output logic OVALID,
    output logic DONE,
    output logic ABORT
);

    localparam int BW = bbox_clog2(CW);
    localparam int KW = bbox_clog2(2 * NV);
    localparam int OW = bbox_clog2(CW + 1);

    localparam logic [BW-1:0] B_LAST = BW'(CW - 1);
    localparam logic [KW-1:0] K_LAST = KW'(2 * NV - 1);
    localparam logic [KW-1:0] K_Y0   = KW'(NV);

    logic [BW-1:0] b_reg;
    logic [KW-1:0] k_reg;
    logic [CW-2:0] sh_reg;
    logic [CW-1:0] xmin_reg, xmax_reg, ymin_reg, ymax_reg;
    logic [OW-1:0] ocnt_reg;
    logic          done_reg, abort_reg;

    logic [CW-1:0] v, cur_min, cur_max, new_min, new_max;
    logic          coord_end, frame_end, is_y, first, abort_cond;
    acc_op_e       acc_op;

    always_comb begin
        v          = {sh_reg, D};
        coord_end  = EN && (b_reg == B_LAST);
        frame_end  = coord_end && (k_reg == K_LAST);
        is_y       = (k_reg >= K_Y0);
        first      = (k_reg == '0) || (k_reg == K_Y0);
        abort_cond = !EN && ((k_reg != '0) || (b_reg != '0));

        acc_op = ACC_HOLD;
        if (coord_end)
            acc_op = first ? ACC_LOAD : ACC_UPDATE;

        cur_min = is_y ? ymin_reg : xmin_reg;
        cur_max = is_y ? ymax_reg : xmax_reg;
        new_min = cur_min;
        new_max = cur_max;
        if (acc_op == ACC_LOAD) begin
            new_min = v;
            new_max = v;
        end else if (acc_op == ACC_UPDATE) begin
            if (v < cur_min) new_min = v;
            if (v > cur_max) new_max = v;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            b_reg     <= '0;
            k_reg     <= '0;
            sh_reg    <= '0;
            xmin_reg  <= '0;
            xmax_reg  <= '0;
            ymin_reg  <= '0;
            ymax_reg  <= '0;
            ocnt_reg  <= '0;
            done_reg  <= 1'b0;
            abort_reg <= 1'b0;
        end else begin
            done_reg  <= frame_end;
            abort_reg <= abort_cond;

            if (EN) begin
                sh_reg <= v[CW-2:0];
                if (b_reg == B_LAST) begin
                    b_reg <= '0;
                    k_reg <= (k_reg == K_LAST) ? '0 : k_reg + KW'(1);
                end else begin
                    b_reg <= b_reg + BW'(1);
                end
                if (coord_end) begin
                    if (is_y) begin
                        ymin_reg <= new_min;
                        ymax_reg <= new_max;
                    end else begin
                        xmin_reg <= new_min;
                        xmax_reg <= new_max;
                    end
                end
            end else begin
                // Any EN-low cycle discards partial-frame state; idle at (0,0) is a no-op.
                b_reg    <= '0;
                k_reg    <= '0;
                sh_reg   <= '0;
                xmin_reg <= '0;
                xmax_reg <= '0;
                ymin_reg <= '0;
                ymax_reg <= '0;
            end

            if (frame_end)
                ocnt_reg <= OW'(CW);
            else if (ocnt_reg != '0)
                ocnt_reg <= ocnt_reg - OW'(1);
        end
    end

    // Y limits come straight from the comparator so the final vertex needs no extra cycle.
    logic [CW-1:0] load_val [4];
    logic [3:0]    msb;

    assign load_val[0] = xmin_reg;
    assign load_val[1] = xmax_reg;
    assign load_val[2] = new_min;
    assign load_val[3] = new_max;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_piso
            bbox_piso #(.W(CW)) u_piso (
                .CLK   (CLK),
                .RST   (RST),
                .load  (frame_end),
                .shift (1'b1),
                .din   (load_val[gi]),
                .msb   (msb[gi])
            );
        end
    endgenerate

    assign OVALID = (ocnt_reg != '0);
    assign XMINI  = msb[0] & OVALID;
    assign XMAXI  = msb[1] & OVALID;
    assign YMINI  = msb[2] & OVALID;
    assign YMAXI  = msb[3] & OVALID;
    assign DONE   = done_reg;
    assign ABORT  = abort_reg;

endmodule

// File: tb/tb_bbox_serial_acc.sv
// Directed bench for bbox_serial_acc: default 9-bit/3-vertex instance plus a 4-bit/1-vertex instance.
module tb_bbox_serial_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d = 1'b0, en = 1'b0;
    logic xmini, xmaxi, ymini, ymaxi, ovalid, done, abort;
    logic d4 = 1'b0, en4 = 1'b0;
    logic s_xmin, s_xmax, s_ymin, s_ymax, s_ovalid, s_done, s_abort;

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0, ov_cnt = 0, done_cnt = 0, abort_cnt = 0;
    int last_done_cyc = 0, prev_done_cyc = 0;
    logic [8:0] cap_xmin = '0, cap_xmax = '0, cap_ymin = '0, cap_ymax = '0;

    always #5 clk = ~clk;

    bbox_serial_acc #(.CW(9), .NV(3)) dut (
        .CLK(clk), .RST(rst), .D(d), .EN(en),
        .XMINI(xmini), .XMAXI(xmaxi), .YMINI(ymini), .YMAXI(ymaxi),
        .OVALID(ovalid), .DONE(done), .ABORT(abort)
    );

    bbox_serial_acc #(.CW(4), .NV(1)) dut_small (
        .CLK(clk), .RST(rst), .D(d4), .EN(en4),
        .XMINI(s_xmin), .XMAXI(s_xmax), .YMINI(s_ymin), .YMAXI(s_ymax),
        .OVALID(s_ovalid), .DONE(s_done), .ABORT(s_abort)
    );

    // Passive monitor on the falling edge: rebuilds the serial words and counts pulses.
    always @(negedge clk) begin
        cyc++;
        if (ovalid) begin
            ov_cnt++;
            cap_xmin = {cap_xmin[7:0], xmini};
            cap_xmax = {cap_xmax[7:0], xmaxi};
            cap_ymin = {cap_ymin[7:0], ymini};
            cap_ymax = {cap_ymax[7:0], ymaxi};
        end
        if (done) begin
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
        end
        if (abort)
            abort_cnt++;
    end

    function automatic logic [53:0] pack(input int x0, x1, x2, y0, y1, y2);
        return {9'(x0), 9'(x1), 9'(x2), 9'(y0), 9'(y1), 9'(y2)};
    endfunction

    task automatic send_frame(input logic [53:0] f);
        for (int i = 53; i >= 0; i--) begin
            en = 1'b1;
            d  = f[i];
            @(posedge clk); #1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        n_vec++;
        if ({xmini, xmaxi, ymini, ymaxi, ovalid, done, abort} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0000000", {xmini, xmaxi, ymini, ymaxi, ovalid, done, abort});
        end
        n_vec++;
        if ({s_xmin, s_xmax, s_ymin, s_ymax, s_ovalid, s_done, s_abort} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs_small: got %b want 0000000", {s_xmin, s_xmax, s_ymin, s_ymax, s_ovalid, s_done, s_abort});
        end
        rst = 1'b0;
        tick(3);
        n_vec++;
        if ({xmini, xmaxi, ymini, ymaxi, ovalid, done, abort} !== 7'b0) begin
            n_err++;
            $display("FAIL idle_outputs: got %b want 0000000", {xmini, xmaxi, ymini, ymaxi, ovalid, done, abort});
        end
        $display("reset: outputs idle");
    endtask

    // Sends one frame, checks DONE/OVALID/MSB timing, then the full serial words.
    task automatic run_frame(input string name, input logic [53:0] f,
                             input logic [8:0] exmin, exmax, eymin, eymax);
        int ov0, dn0;
        ov0 = ov_cnt;
        dn0 = done_cnt;
        send_frame(f);
        en = 1'b0;
        n_vec++;
        if ({done, ovalid} !== 2'b11) begin
            n_err++;
            $display("FAIL %s_done_ovalid: got %b want 11", name, {done, ovalid});
        end
        n_vec++;
        if ({xmini, xmaxi, ymini, ymaxi} !== {exmin[8], exmax[8], eymin[8], eymax[8]}) begin
            n_err++;
            $display("FAIL %s_msb_first: got %b want %b", name, {xmini, xmaxi, ymini, ymaxi},
                     {exmin[8], exmax[8], eymin[8], eymax[8]});
        end
        tick(9);
        n_vec++;
        if ({cap_xmin, cap_xmax, cap_ymin, cap_ymax} !== {exmin, exmax, eymin, eymax}) begin
            n_err++;
            $display("FAIL %s_limits: got %0d %0d %0d %0d want %0d %0d %0d %0d", name,
                     cap_xmin, cap_xmax, cap_ymin, cap_ymax, exmin, exmax, eymin, eymax);
        end
        n_vec++;
        if (ov_cnt - ov0 !== 9 || done_cnt - dn0 !== 1) begin
            n_err++;
            $display("FAIL %s_pulse_len: ovalid %0d done %0d want 9 1", name, ov_cnt - ov0, done_cnt - dn0);
        end
        n_vec++;
        if ({xmini, xmaxi, ymini, ymaxi, ovalid} !== 5'b0) begin
            n_err++;
            $display("FAIL %s_after_output: got %b want 00000", name, {xmini, xmaxi, ymini, ymaxi, ovalid});
        end
        $display("frame %s: xmin=%0d xmax=%0d ymin=%0d ymax=%0d", name, cap_xmin, cap_xmax, cap_ymin, cap_ymax);
    endtask

    task automatic test_basic;
        run_frame("basic", pack(10, 300, 5, 200, 7, 511), 9'd5, 9'd300, 9'd7, 9'd511);
    endtask

    task automatic test_equal;
        run_frame("all42", pack(42, 42, 42, 42, 42, 42), 9'd42, 9'd42, 9'd42, 9'd42);
        run_frame("extremes", pack(0, 0, 0, 511, 511, 511), 9'd0, 9'd0, 9'd511, 9'd511);
    endtask

    task automatic test_back_to_back;
        logic [53:0] f2;
        f2 = pack(1, 2, 3, 4, 5, 6);
        send_frame(pack(10, 300, 5, 200, 7, 511));
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done1: got %b want 1", done);
        end
        for (int i = 53; i >= 0; i--) begin
            en = 1'b1;
            d  = f2[i];
            @(posedge clk); #1;
            if (i == 45) begin
                n_vec++;
                if ({cap_xmin, cap_xmax, cap_ymin, cap_ymax} !== {9'd5, 9'd300, 9'd7, 9'd511}) begin
                    n_err++;
                    $display("FAIL b2b_limits1: got %0d %0d %0d %0d want 5 300 7 511",
                             cap_xmin, cap_xmax, cap_ymin, cap_ymax);
                end
            end
        end
        en = 1'b0;
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done2: got %b want 1", done);
        end
        tick(9);
        n_vec++;
        if (last_done_cyc - prev_done_cyc !== 54) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d want 54", last_done_cyc - prev_done_cyc);
        end
        n_vec++;
        if ({cap_xmin, cap_xmax, cap_ymin, cap_ymax} !== {9'd1, 9'd3, 9'd4, 9'd6}) begin
            n_err++;
            $display("FAIL b2b_limits2: got %0d %0d %0d %0d want 1 3 4 6", cap_xmin, cap_xmax, cap_ymin, cap_ymax);
        end
        $display("frame b2b: xmin=%0d xmax=%0d ymin=%0d ymax=%0d", cap_xmin, cap_xmax, cap_ymin, cap_ymax);
    endtask

    task automatic test_abort;
        logic [53:0] junk;
        int dn0, ab0;
        junk = pack(511, 511, 0, 0, 0, 0);
        dn0 = done_cnt;
        ab0 = abort_cnt;
        for (int i = 53; i > 33; i--) begin
            en = 1'b1;
            d  = junk[i];
            @(posedge clk); #1;
        end
        en = 1'b0;
        d  = 1'b0;
        tick(1);
        n_vec++;
        if ({abort, done} !== 2'b10) begin
            n_err++;
            $display("FAIL abort_pulse: got abort,done=%b want 10", {abort, done});
        end
        tick(1);
        n_vec++;
        if (abort !== 1'b0 || abort_cnt - ab0 !== 1 || done_cnt - dn0 !== 0) begin
            n_err++;
            $display("FAIL abort_single: abort %b count %0d done %0d want 0 1 0", abort, abort_cnt - ab0, done_cnt - dn0);
        end
        $display("abort: partial frame dropped after 20 bits");
        run_frame("post_abort", pack(100, 50, 75, 9, 8, 10), 9'd50, 9'd100, 9'd8, 9'd10);
    endtask

    task automatic test_reset_mid_output;
        send_frame(pack(10, 300, 5, 200, 7, 511));
        en = 1'b0;
        tick(4);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({xmini, xmaxi, ymini, ymaxi, ovalid, done, abort} !== 7'b0) begin
            n_err++;
            $display("FAIL rst_mid_output: got %b want 0000000", {xmini, xmaxi, ymini, ymaxi, ovalid, done, abort});
        end
        #1;
        rst = 1'b0;
        tick(2);
        $display("reset: asserted during 5th output bit");
        run_frame("post_reset", pack(10, 300, 5, 200, 7, 511), 9'd5, 9'd300, 9'd7, 9'd511);
    endtask

    task automatic test_small;
        logic [7:0] f;
        logic [3:0] ex, ey;
        f  = 8'b1001_0011;
        ex = 4'b1001;
        ey = 4'b0011;
        for (int i = 7; i >= 0; i--) begin
            en4 = 1'b1;
            d4  = f[i];
            @(posedge clk); #1;
        end
        en4 = 1'b0;
        n_vec++;
        if ({s_done, s_ovalid} !== 2'b11) begin
            n_err++;
            $display("FAIL small_done: got %b want 11", {s_done, s_ovalid});
        end
        for (int j = 3; j >= 0; j--) begin
            n_vec++;
            if ({s_xmin, s_xmax, s_ymin, s_ymax} !== {ex[j], ex[j], ey[j], ey[j]}) begin
                n_err++;
                $display("FAIL small_bit%0d: got %b want %b", j, {s_xmin, s_xmax, s_ymin, s_ymax},
                         {ex[j], ex[j], ey[j], ey[j]});
            end
            tick(1);
        end
        n_vec++;
        if ({s_ovalid, s_done, s_xmin, s_xmax, s_ymin, s_ymax} !== 6'b0) begin
            n_err++;
            $display("FAIL small_end: got %b want 000000", {s_ovalid, s_done, s_xmin, s_xmax, s_ymin, s_ymax});
        end
        $display("frame small: x=9 y=3 shifted out over 4 cycles");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_basic;
        test_equal;
        test_back_to_back;
        tick(3);
        test_abort;
        test_reset_mid_output;
        test_small;
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bbox_serial_acc.md
# bbox_serial_acc

Parametrised successor of the fixed 3-vertex, 9-bit bounding-box unit. Accepts a bit-serial stream of NV vertex coordinates per frame, keeps running minimum and maximum on the fly instead of buffering the whole frame, and shifts the four bounding-box limits out bit-serially, MSB first, in parallel with reception of the next frame. Sits between the serial vertex source and the rasteriser's serial tile-range inputs.

## Interface
- CW, default 9: coordinate width in bits, unsigned, CW ≥ 2.
- NV, default 3: vertices per frame, NV ≥ 1.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- D  in  1  serial data; sampled on every CLK edge where EN=1.
- EN  in  1  frame enable; high for the whole frame; low aborts any partial frame.
- XMINI, XMAXI, YMINI, YMAXI  out  1 each  serial bounding-box limits, MSB first.
- OVALID  out  1  high during the CW cycles in which the serial outputs carry valid bits.
- DONE  out  1  one-cycle pulse when a frame completes.
- ABORT  out  1  one-cycle pulse when EN drops mid-frame.

## Operation
- Frame format: x0..x(NV-1), then y0..y(NV-1); each coordinate CW bits, MSB first. Frame length L = 2·NV·CW sampled bits.
- Counters: bit index b (0..CW-1), coordinate index k (0..2NV-1). Advance only when EN=1. Wrap b→0 and k→k+1 at b=CW-1. At k=2NV-1 and b=CW-1, wrap to k=0, b=0 (back-to-back frames need no gap).
- Deserialiser: CW-bit shift register, shifting left with D entering the LSB. Completed value v = {sh[CW-2:0], D} is formed on the edge with b=CW-1.
- Accumulate: at k=0, load XMIN=XMAX=v. For 0<k<NV, update XMIN=min(XMIN,v) and XMAX=max(XMAX,v). At k=NV, load YMIN=YMAX=v. For k>NV, update the Y pair the same way. Unsigned compare. Equal values leave the result unchanged.
- Frame end, on the edge with k=2NV-1 and b=CW-1:
  - Load the four output shift registers with the final X pair and the Y pair updated with v, bypassing the accumulator.
  - Set OVALID, pulse DONE.
- Output: each edge after load shifts all four registers left by one. Serial outputs = register MSBs. An output down-counter clears OVALID after CW cycles. Outside OVALID the serial outputs are 0.
- Abort: EN=0 while (k,b)≠(0,0) resets b, k and the deserialiser, discards the accumulators, and pulses ABORT next cycle. Output shifting in progress continues unaffected. EN=0 at (0,0) is idle: no ABORT.

## Timing
- Reset values: all outputs 0, counters 0, accumulators 0, output registers 0.
- RST is asynchronous. Asserting it mid-frame or mid-output clears everything immediately. The first frame after release starts on the first edge with EN=1.
- Latency: the MSB of each limit appears in the cycle right after the edge that samples the frame's last bit. The LSB follows CW-1 cycles later.
- DONE and OVALID rise together. OVALID stays high for exactly CW cycles.
- Overlap: L ≥ 2·CW > CW, so output of frame n always ends before frame n+1 completes. There is no collision and no stall.
- Abort on the final-bit cycle (EN=0 there) means the frame is not completed: no DONE, ABORT pulses.

## Structure
- Shared package bbox_pkg:
  - default CW and NV;
  - function bbox_clog2 for counter widths (b: clog2(CW), k: clog2(2NV), output counter: clog2(CW+1));
  - localparam L.
- Sub-module bbox_piso: CW-bit load/shift register with MSB serial out. Instantiated four times. Load has priority over shift.
- Min/max update and counters stay inline in bbox_serial_acc.

## Test plan
- CW=9, NV=3; x=(10,300,5), y=(200,7,511) -> DONE one cycle after the 54th bit. XMINI serial 000000101 (5), XMAXI 100101100 (300), YMINI 000000111 (7), YMAXI 111111111 (511). OVALID high exactly 9 cycles.
- All coordinates equal 42 -> all four limits 000101010. Frame with x=(0,0,0) and y=(511,511,511) -> XMIN=XMAX=0, YMIN=YMAX=511.
- Two frames back-to-back with EN held high for 108 cycles: frame 1 as in the first scenario, frame 2 x=(1,2,3), y=(4,5,6) -> two DONE pulses 54 cycles apart. Second output XMIN=1, XMAX=3, YMIN=4, YMAX=6.
- EN dropped after 20 bits, then a full clean frame -> ABORT pulse after the drop and no DONE. Clean frame results unaffected by the partial data.
- RST asserted during the 5th output bit -> all outputs 0 immediately, OVALID 0. The next frame after release produces correct results.
- CW=4, NV=1; x=9, y=3 -> XMIN=XMAX=1001, YMIN=YMAX=0011. DONE 8 cycles after the frame starts.
